// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t   : FSM encoding used by seq_multiplier (IDLE / CALC / DONE)
//   WIDTH_MIN : smallest legal operand width
//   WIDTH_MAX : largest legal operand width
package seq_mult_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath for seq_multiplier: accumulator, left-shifting
// multiplicand, right-shifting multiplier and iteration counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture operands, clear accumulator, load counter with WIDTH
//   step       : perform one shift-add iteration
//   a_mag      : multiplicand (unsigned magnitude)
//   b_mag      : multiplier (unsigned magnitude)
//   last       : the current step is the final (WIDTH-th) iteration
//   sum        : accumulator plus this iteration's partial product
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic                 last,
  output logic [2*WIDTH-1:0]   sum
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a_mag};
      mplr  <= b_mag;
      cnt   <= CW'(WIDTH);
    end else if (step) begin
      acc   <= sum;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt - CW'(1);
    end
  end

  // Exposed combinationally so the final iteration's result can be
  // registered into P on the same edge that ends CALC.
  assign sum  = acc + (mplr[0] ? mcand : '0);
  assign last = (cnt == CW'(1));

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with fixed WIDTH-cycle latency.
// Optional feature macro: SEQ_MULT_SIGNED_EN (adds sign_mode and
// two's-complement support via magnitude multiply plus final negation).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : begin a multiply (honoured only in IDLE)
//   sign_mode : [SEQ_MULT_SIGNED_EN only] 1 = signed operands, sampled with start
//   A, B      : multiplicand, multiplier
//   busy      : high in CALC and DONE
//   done      : one-cycle pulse, P valid while high
//   P         : registered 2*WIDTH-bit product, held until the next DONE
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               sign_mode,
`endif
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_multiplier: WIDTH out of legal range");
  end

  state_t             state, next_state;
  logic               load, step, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] sum, p_next;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;

  always_comb begin
    a_mag = (sign_mode && A[WIDTH-1]) ? -A : A;
    b_mag = (sign_mode && B[WIDTH-1]) ? -B : B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (load) begin
      neg <= sign_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    end
  end

  assign p_next = neg ? -sum : sum;
`else
  assign a_mag  = A;
  assign b_mag  = B;
  assign p_next = sum;
`endif

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .last  (last),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = CALC;
          load       = 1'b1;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P <= '0;
    end else if (step && last) begin
      P <= p_next;
    end
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 SHALL have port: A  input  WIDTH  multiplicand.
REQ-006 SHALL have port: B  input  WIDTH  multiplier.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress (states CALC and DONE).
REQ-008 SHALL have port: done  output  1  single-cycle pulse; P is valid while done is high.
REQ-009 SHALL have port: P  output  2*WIDTH  product, registered.
REQ-010 SHALL have, only when SEQ_MULT_SIGNED_EN is defined, port: sign_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-012 IDLE -> CALC SHALL occur on an edge where start=1; the same edge SHALL latch A, B (and sign_mode), clear the accumulator and load the iteration counter.
REQ-013 start SHALL be ignored in CALC and DONE; start=1 while busy=1 SHALL NOT restart or corrupt the operation.
REQ-014 CALC SHALL perform one shift-add iteration per cycle for exactly WIDTH cycles, regardless of operand values; zero operands are not shortcut.
REQ-015 CALC -> DONE SHALL occur on the WIDTH-th edge after acceptance; P SHALL be updated on that edge and done=1 for exactly that cycle.
REQ-016 DONE -> IDLE SHALL be unconditional on the next edge; busy=0 and done=0 from then on.
REQ-017 Latency SHALL be fixed: done high in the cycle following edge WIDTH after the accepting edge; the earliest next accept is edge WIDTH+2.
REQ-018 P SHALL hold its value from DONE until the next DONE and SHALL NOT change during CALC.
REQ-019 Changes on A/B/sign_mode while busy=1 SHALL have no effect on the result.
REQ-020 The unsigned product SHALL be exact in 2*WIDTH bits; no overflow is possible.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, P=0, and clear the internal operand, accumulator and counter registers, with no clock required.
REQ-022 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-023 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro SEQ_MULT_SIGNED_EN defined: sign_mode exists; signed operation SHALL latch operand magnitudes, run the unsigned core, and negate the result when the operand signs differ; latency is unchanged.
REQ-025 SEQ_MULT_SIGNED_EN undefined: no sign_mode port; the block is unsigned-only and carries no sign logic.

Structure
REQ-026 Package seq_mult_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE) and the WIDTH legal-range constants.
REQ-027 Sub-module seq_mult_datapath (accumulator, shifted multiplicand, multiplier shift register, counter) SHALL be instantiated by seq_multiplier; the FSM SHALL live in the top.

Verification
REQ-028 WIDTH=3: rst_n low then release; start with A=3'b101, B=3'b011 -> done after 3 CALC cycles, P=6'd15, busy low one cycle later.
REQ-029 WIDTH=3: A=3'b111, B=3'b111 -> P=6'd49; then A=0, B=7 -> P=0 with the same fixed latency.
REQ-030 WIDTH=8: A=8'd200, B=8'd150; pulse start again and change A to 8'd1 mid-CALC -> single done, P=16'd30000, second start ignored.
REQ-031 WIDTH=8: start accepted, rst_n asserted after 4 cycles -> P=0, busy=0, no done pulse; a new start with A=8'd3, B=8'd4 -> P=16'd12.
REQ-032 SEQ_MULT_SIGNED_EN, WIDTH=3, sign_mode=1: A=3'b100 (-4), B=3'b011 (3) -> P=6'b110100 (-12); A=-4, B=-4 -> P=6'd16.
REQ-033 Back-to-back: start held high continuously with WIDTH=4 -> accepts at edges 0, 6, 12; each done is a one-cycle pulse with the correct product.
